// File: rtl/branch_pkg.sv
// branch_pkg: types shared by the branch predictor and its outcome tracker
package branch_pkg;
  typedef enum logic [1:0] {
    STRONG_NOT_TAKEN = 2'd0,
    WEAK_NOT_TAKEN   = 2'd1,
    WEAK_TAKEN       = 2'd2,
    STRONG_TAKEN     = 2'd3
  } ctr_t;
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;
  localparam int ENTRY_PC_W = 8;
  typedef struct packed {
    logic                  taken;
    logic [ENTRY_PC_W-1:0] pc;
  } entry_t;
endpackage

// File: rtl/bt_fifo.sv
// bt_fifo: synchronous in-order queue with push/pop/clear and occupancy count
module bt_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push && !clear) mem[wr_ptr] <= din;
endmodule

// File: rtl/branch_outcome_tracker.sv
// branch_outcome_tracker: queues predictions, scores them on resolve, trains the predictor and flushes on mispredict
module branch_outcome_tracker
  import branch_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int PC_W         = ENTRY_PC_W,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic             pred_taken,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             upd_result,
  output logic             upd_taken,
  output logic             mispredict,
  output logic [PC_W-1:0]  mispredict_pc,
  output logic [CNT_W-1:0] correct_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  state_t        state;
  logic [FW-1:0] flush_cnt;
  entry_t        head, tail;
  logic          full, empty, pop, mis, push;
  logic [AW:0]   occupancy;
  assign pred_ready = !rst && state == RUN && !full;
  assign pop        = res_valid && !empty;
  assign mis        = pop && (head.taken != res_taken);
  // younger entries are wrong-path on a mispredict, so a same-cycle push is dropped
  assign push       = pred_valid && pred_ready && !mis;
  assign tail       = '{taken: pred_taken, pc: pred_pc};
  bt_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .clear(mis),
    .din(tail), .dout(head), .full(full), .empty(empty), .count(occupancy)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else if (mis) begin
      state     <= FLUSH;
      flush_cnt <= FW'(FLUSH_CYCLES - 1);
    end else if (state == FLUSH) begin
      state     <= flush_cnt == '0 ? RUN : FLUSH;
      flush_cnt <= flush_cnt == '0 ? '0 : flush_cnt - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_result    <= 1'b0;
      upd_taken     <= 1'b0;
      mispredict    <= 1'b0;
      mispredict_pc <= '0;
      correct_cnt   <= '0;
      mispred_cnt   <= '0;
      underflow     <= 1'b0;
    end else begin
      upd_result    <= pop;
      upd_taken     <= pop && res_taken;
      mispredict    <= mis;
      mispredict_pc <= mis ? head.pc : '0;
      if (pop && !mis && correct_cnt != '1) correct_cnt <= correct_cnt + 1'b1;
      if (mis && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 1'b1;
      if (res_valid && empty) underflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) if (!rst) assert (occupancy <= (AW+1)'(DEPTH));
endmodule

// File: tb/tb_branch_outcome_tracker.sv
// tb_branch_outcome_tracker: directed vector table plus hand-written reset/flush sequences
module tb_branch_outcome_tracker;
  logic        clk = 1'b0, rst = 1'b1;
  logic        pred_valid = 1'b0, pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
  logic [7:0]  pred_pc = '0;
  logic        pred_ready, upd_result, upd_taken, mispredict, underflow;
  logic [7:0]  mispredict_pc;
  logic [15:0] correct_cnt, mispred_cnt;
  logic        s_ready, s_ur, s_ut, s_mp, s_under;
  logic [7:0]  s_mpc;
  logic [1:0]  s_correct, s_mispred;
  int checks = 0, errors = 0, done = 0;

  typedef struct {
    logic pv, pt; logic [7:0] pc; logic rv, rt;
    logic rdy, ur, ut, mp; logic [7:0] mpc;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  branch_outcome_tracker dut (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc),
    .pred_ready(pred_ready), .res_valid(res_valid), .res_taken(res_taken),
    .upd_result(upd_result), .upd_taken(upd_taken), .mispredict(mispredict),
    .mispredict_pc(mispredict_pc), .correct_cnt(correct_cnt), .mispred_cnt(mispred_cnt),
    .underflow(underflow)
  );

  branch_outcome_tracker #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc),
    .pred_ready(s_ready), .res_valid(res_valid), .res_taken(res_taken),
    .upd_result(s_ur), .upd_taken(s_ut), .mispredict(s_mp),
    .mispredict_pc(s_mpc), .correct_cnt(s_correct), .mispred_cnt(s_mispred),
    .underflow(s_under)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic pv, pt, input logic [7:0] pc, input logic rv, rt,
                     input logic rdy, ur, ut, mp, input logic [7:0] mpc);
    vec_t v;
    v = '{pv:pv, pt:pt, pc:pc, rv:rv, rt:rt, rdy:rdy, ur:ur, ut:ut, mp:mp, mpc:mpc};
    tbl.push_back(v);
  endtask

  task automatic run_tbl();
    while (done < tbl.size()) begin
      @(negedge clk);
      pred_valid = tbl[done].pv; pred_taken = tbl[done].pt; pred_pc = tbl[done].pc;
      res_valid = tbl[done].rv; res_taken = tbl[done].rt;
      #1 chk($sformatf("v%0d pred_ready", done), pred_ready, tbl[done].rdy);
      @(posedge clk); #1;
      chk($sformatf("v%0d upd_result", done), upd_result, tbl[done].ur);
      chk($sformatf("v%0d upd_taken", done), upd_taken, tbl[done].ut);
      chk($sformatf("v%0d mispredict", done), mispredict, tbl[done].mp);
      chk($sformatf("v%0d mispredict_pc", done), mispredict_pc, tbl[done].mpc);
      done++;
    end
    @(negedge clk);
    pred_valid = 0; res_valid = 0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    pred_valid = 0; res_valid = 0; rst = 1;
    #1 chk("rst pred_ready", pred_ready, 0);
    @(posedge clk); #1;
    chk("rst upd_result", upd_result, 0);
    chk("rst mispredict", mispredict, 0);
    chk("rst mispredict_pc", mispredict_pc, 0);
    chk("rst correct_cnt", correct_cnt, 0);
    chk("rst mispred_cnt", mispred_cnt, 0);
    chk("rst underflow", underflow, 0);
    @(negedge clk);
    rst = 0;
    #1 chk("post-rst pred_ready", pred_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    pulse_rst();
    // fill to DEPTH, then a fifth prediction must be dropped
    add(1,1,8'h10, 0,0, 1, 0,0,0,8'h00);
    add(1,0,8'h14, 0,0, 1, 0,0,0,8'h00);
    add(1,1,8'h18, 0,0, 1, 0,0,0,8'h00);
    add(1,0,8'h1C, 0,0, 1, 0,0,0,8'h00);
    add(1,1,8'h40, 0,0, 0, 0,0,0,8'h00);
    add(0,0,8'h00, 1,1, 0, 1,1,0,8'h00);
    add(0,0,8'h00, 1,0, 1, 1,0,0,8'h00);
    add(0,0,8'h00, 1,1, 1, 1,1,0,8'h00);
    add(0,0,8'h00, 1,0, 1, 1,0,0,8'h00);
    add(0,0,8'h00, 0,0, 1, 0,0,0,8'h00);
    run_tbl();
    chk("s2 correct_cnt", correct_cnt, 4);
    chk("s2 mispred_cnt", mispred_cnt, 0);
    chk("s2 saturated correct_cnt", s_correct, 3);
    chk("s2 underflow", underflow, 0);
    // mispredict on the oldest entry, then two cycles of throttling
    add(1,1,8'h20, 0,0, 1, 0,0,0,8'h00);
    add(1,1,8'h24, 0,0, 1, 0,0,0,8'h00);
    add(1,0,8'h28, 0,0, 1, 0,0,0,8'h00);
    add(0,0,8'h00, 1,0, 1, 1,0,1,8'h20);
    add(0,0,8'h00, 0,0, 0, 0,0,0,8'h00);
    add(0,0,8'h00, 0,0, 0, 0,0,0,8'h00);
    add(0,0,8'h00, 0,0, 1, 0,0,0,8'h00);
    run_tbl();
    chk("s3 mispred_cnt", mispred_cnt, 1);
    chk("s3 correct_cnt", correct_cnt, 4);
    // push concurrent with a mispredict is discarded; later resolve underflows
    add(1,1,8'h2C, 0,0, 1, 0,0,0,8'h00);
    add(1,1,8'h30, 1,0, 1, 1,0,1,8'h2C);
    add(0,0,8'h00, 0,0, 0, 0,0,0,8'h00);
    add(0,0,8'h00, 1,1, 0, 0,0,0,8'h00);
    add(0,0,8'h00, 0,0, 1, 0,0,0,8'h00);
    add(0,0,8'h00, 1,1, 1, 0,0,0,8'h00);
    run_tbl();
    chk("s4 underflow", underflow, 1);
    chk("s4 mispred_cnt", mispred_cnt, 2);
    chk("s4 correct_cnt", correct_cnt, 4);
    // full queue: pop without bypass, then steady push+pop across pointer wrap
    add(1,1,8'h50, 0,0, 1, 0,0,0,8'h00);
    add(1,0,8'h54, 0,0, 1, 0,0,0,8'h00);
    add(1,1,8'h58, 0,0, 1, 0,0,0,8'h00);
    add(1,1,8'h5C, 0,0, 1, 0,0,0,8'h00);
    add(1,1,8'h60, 1,1, 0, 1,1,0,8'h00);
    add(1,0,8'h64, 1,0, 1, 1,0,0,8'h00);
    add(1,1,8'h68, 1,1, 1, 1,1,0,8'h00);
    add(0,0,8'h00, 1,1, 1, 1,1,0,8'h00);
    add(0,0,8'h00, 1,0, 1, 1,0,0,8'h00);
    add(0,0,8'h00, 1,0, 1, 1,0,1,8'h68);
    add(0,0,8'h00, 0,0, 0, 0,0,0,8'h00);
    add(0,0,8'h00, 0,0, 0, 0,0,0,8'h00);
    add(0,0,8'h00, 0,0, 1, 0,0,0,8'h00);
    run_tbl();
    chk("s5 correct_cnt", correct_cnt, 9);
    chk("s5 mispred_cnt", mispred_cnt, 3);
    chk("s5 saturated correct_cnt", s_correct, 3);
    chk("s5 saturated mispred_cnt", s_mispred, 3);
    // reset in the middle of a flush window
    add(1,1,8'h70, 0,0, 1, 0,0,0,8'h00);
    add(1,0,8'h74, 0,0, 1, 0,0,0,8'h00);
    add(0,0,8'h00, 1,0, 1, 1,0,1,8'h70);
    run_tbl();
    pulse_rst();
    // reset with entries pending: they vanish and never train the predictor
    add(1,1,8'h80, 0,0, 1, 0,0,0,8'h00);
    add(1,1,8'h84, 0,0, 1, 0,0,0,8'h00);
    run_tbl();
    pulse_rst();
    add(0,0,8'h00, 1,1, 1, 0,0,0,8'h00);
    add(0,0,8'h00, 0,0, 1, 0,0,0,8'h00);
    run_tbl();
    chk("s6 underflow", underflow, 1);
    chk("s6 correct_cnt", correct_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
